// File: rtl/cmlk_multich_pulse_seq_if.sv
// Bundle between the parameter register bank and the pulse sequencer.
// Parameters are laser/gate timing, delay sweep and decimation; status and pulse outputs come back.
// master : parameter bank side (drives controls/parameters, observes pulses and status)
// slave  : sequencer side (consumes controls/parameters, drives pulses and status)
interface cmlk_multich_pulse_seq_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned STEP_W = 8,
    parameter int unsigned CYC_W  = 8,
    parameter int unsigned DECI_W = 16
);
    logic                       enable;
    logic                       load_param;
    logic [CNT_W-1:0]           laser_period;
    logic [CNT_W-1:0]           laser_width;
    logic [NUM_CH*CNT_W-1:0]    ch_delay;
    logic [NUM_CH*CNT_W-1:0]    ch_width;
    logic [NUM_CH*STEP_W-1:0]   ch_step;
    logic [CYC_W-1:0]           cycles_m;
    logic [CYC_W-1:0]           steps_n;
    logic [DECI_W-1:0]          bg_deci_n;

    logic                       laser_pulse;
    logic [NUM_CH-1:0]          gate_pulse;
    logic                       frame_start;
    logic                       frame_bg;
    logic [CYC_W-1:0]           step_idx;
    logic                       busy;
    logic                       load_pending;

    modport master (
        output enable, load_param, laser_period, laser_width, ch_delay, ch_width,
               ch_step, cycles_m, steps_n, bg_deci_n,
        input  laser_pulse, gate_pulse, frame_start, frame_bg, step_idx, busy, load_pending
    );

    modport slave (
        input  enable, load_param, laser_period, laser_width, ch_delay, ch_width,
               ch_step, cycles_m, steps_n, bg_deci_n,
        output laser_pulse, gate_pulse, frame_start, frame_bg, step_idx, busy, load_pending
    );
endinterface

// File: rtl/cmlk_multich_pulse_seq.sv
// Multi-channel laser/gate pulse sequencer.
// One period counter drives a laser pulse train and NUM_CH gate channels whose
// delays sweep by a per-channel step across a frame; laser is suppressed on
// decimated background frames. Parameters are shadowed and only change at
// frame boundaries while running.
// Ports:
//   clk : block clock
//   rst : asynchronous reset, active-high
//   bus : slave side of cmlk_multich_pulse_seq_if (controls, parameters, pulses, status)
module cmlk_multich_pulse_seq #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned STEP_W = 8,
    parameter int unsigned CYC_W  = 8,
    parameter int unsigned DECI_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    cmlk_multich_pulse_seq_if.slave bus
);
    localparam int unsigned EW  = CNT_W + CYC_W + STEP_W;
    localparam int unsigned EW1 = EW + 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    // Shadow parameter set
    logic [CNT_W-1:0]           r_sh_period;
    logic [CNT_W-1:0]           r_sh_lwidth;
    logic [NUM_CH*CNT_W-1:0]    r_sh_delay;
    logic [NUM_CH*CNT_W-1:0]    r_sh_width;
    logic [NUM_CH*STEP_W-1:0]   r_sh_step;
    logic [CYC_W-1:0]           r_sh_cyc;
    logic [CYC_W-1:0]           r_sh_steps;
    logic [DECI_W-1:0]          r_sh_deci;
    logic                       r_pending;

    // Timing counters
    logic [CNT_W-1:0]           r_period_cnt;
    logic [CYC_W-1:0]           r_cyc_cnt;
    logic [CYC_W-1:0]           r_step_cnt;
    logic [DECI_W-1:0]          r_frame_cnt;

    // Registered outputs
    logic                       r_laser;
    logic [NUM_CH-1:0]          r_gate;
    logic                       r_fs;
    logic                       r_bg;
    logic [CYC_W-1:0]           r_step_o;

    logic [CNT_W-1:0]           w_period;
    logic [CYC_W-1:0]           w_cyc;
    logic [CYC_W-1:0]           w_steps;
    logic                       w_period_last;
    logic                       w_cyc_last;
    logic                       w_step_last;
    logic                       w_frame_end;
    logic                       w_load_now;
    logic                       w_bg_now;
    logic [NUM_CH-1:0]          w_gate_hit;

    logic                       w_laser_d;
    logic [NUM_CH-1:0]          w_gate_d;
    logic                       w_fs_d;
    logic                       w_bg_d;
    logic [CYC_W-1:0]           w_step_d;

    // Sanitised shadow values
    assign w_period = (r_sh_period < CNT_W'(2)) ? CNT_W'(2) : r_sh_period;
    assign w_cyc    = (r_sh_cyc   == '0) ? CYC_W'(1) : r_sh_cyc;
    assign w_steps  = (r_sh_steps == '0) ? CYC_W'(1) : r_sh_steps;

    assign w_period_last = (r_period_cnt == w_period - CNT_W'(1));
    assign w_cyc_last    = (r_cyc_cnt    == w_cyc    - CYC_W'(1));
    assign w_step_last   = (r_step_cnt   == w_steps  - CYC_W'(1));
    assign w_frame_end   = (r_state == ST_RUN) && w_period_last && w_cyc_last && w_step_last;

    // A request left pending when the sequencer stops is applied in IDLE.
    assign w_load_now = (r_state == ST_IDLE) ? (bus.load_param || r_pending)
                                             : (w_frame_end && (bus.load_param || r_pending));

    assign w_bg_now = (r_sh_deci != '0) && (r_frame_cnt == r_sh_deci - DECI_W'(1));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.enable)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!bus.enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow registers and pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_period <= '0;
            r_sh_lwidth <= '0;
            r_sh_delay  <= '0;
            r_sh_width  <= '0;
            r_sh_step   <= '0;
            r_sh_cyc    <= '0;
            r_sh_steps  <= '0;
            r_sh_deci   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_load_now) begin
                r_sh_period <= bus.laser_period;
                r_sh_lwidth <= bus.laser_width;
                r_sh_delay  <= bus.ch_delay;
                r_sh_width  <= bus.ch_width;
                r_sh_step   <= bus.ch_step;
                r_sh_cyc    <= bus.cycles_m;
                r_sh_steps  <= bus.steps_n;
                r_sh_deci   <= bus.bg_deci_n;
                r_pending   <= 1'b0;
            end else if (bus.load_param) begin
                r_pending   <= 1'b1;
            end
        end
    end

    // Period / cycle / step / frame counters; held at zero outside RUN so
    // entry into RUN always starts a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_cyc_cnt    <= '0;
            r_step_cnt   <= '0;
            r_frame_cnt  <= '0;
        end else if (r_state == ST_RUN && bus.enable) begin
            if (w_period_last) begin
                r_period_cnt <= '0;
                if (w_cyc_last) begin
                    r_cyc_cnt <= '0;
                    if (w_step_last) begin
                        r_step_cnt <= '0;
                        // >= guards against a smaller bg_deci_n loaded mid-run
                        if (r_sh_deci == '0 || r_frame_cnt >= r_sh_deci - DECI_W'(1))
                            r_frame_cnt <= '0;
                        else
                            r_frame_cnt <= r_frame_cnt + DECI_W'(1);
                    end else begin
                        r_step_cnt <= r_step_cnt + CYC_W'(1);
                    end
                end else begin
                    r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                end
            end else begin
                r_period_cnt <= r_period_cnt + CNT_W'(1);
            end
        end else begin
            r_period_cnt <= '0;
            r_cyc_cnt    <= '0;
            r_step_cnt   <= '0;
            r_frame_cnt  <= '0;
        end
    end

    // Per-channel gate window, evaluated with enough width that delay + step
    // sweep + width never wraps; the period counter bound clips the window.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [EW-1:0]  w_eff;
        logic [EW1-1:0] w_end;
        logic [EW1-1:0] w_pos;

        assign w_eff = EW'(r_sh_delay[g*CNT_W +: CNT_W])
                     + EW'(r_step_cnt) * EW'(r_sh_step[g*STEP_W +: STEP_W]);
        assign w_end = EW1'(w_eff) + EW1'(r_sh_width[g*CNT_W +: CNT_W]);
        assign w_pos = EW1'(r_period_cnt);
        assign w_gate_hit[g] = (w_pos >= EW1'(w_eff)) && (w_pos < w_end);
    end

    // FSM outputs (next values of the registered pulse/status outputs)
    always_comb begin
        w_laser_d = 1'b0;
        w_gate_d  = '0;
        w_fs_d    = 1'b0;
        w_bg_d    = 1'b0;
        w_step_d  = '0;
        if (r_state == ST_RUN) begin
            w_bg_d    = w_bg_now;
            w_laser_d = !w_bg_now && (r_period_cnt < r_sh_lwidth);
            w_gate_d  = w_gate_hit;
            w_fs_d    = (r_period_cnt == '0) && (r_cyc_cnt == '0) && (r_step_cnt == '0);
            w_step_d  = r_step_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_laser  <= 1'b0;
            r_gate   <= '0;
            r_fs     <= 1'b0;
            r_bg     <= 1'b0;
            r_step_o <= '0;
        end else begin
            r_laser  <= w_laser_d;
            r_gate   <= w_gate_d;
            r_fs     <= w_fs_d;
            r_bg     <= w_bg_d;
            r_step_o <= w_step_d;
        end
    end

    assign bus.laser_pulse  = r_laser;
    assign bus.gate_pulse   = r_gate;
    assign bus.frame_start  = r_fs;
    assign bus.frame_bg     = r_bg;
    assign bus.step_idx     = r_step_o;
    assign bus.busy         = (r_state == ST_RUN);
    assign bus.load_pending = r_pending;
endmodule

// File: tb/tb_cmlk_multich_pulse_seq.sv
// Scoreboard bench for cmlk_multich_pulse_seq (NUM_CH=2).
// Stimulus pushes per-cycle expected output vectors for whole frames; the
// monitor starts popping at the first frame_start seen with work queued.
module tb_cmlk_multich_pulse_seq;
    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 32;
    localparam int unsigned SW  = 8;
    localparam int unsigned YW  = 8;
    localparam int unsigned DW  = 16;

    // {laser, gate1, gate0, frame_start, frame_bg, step_idx[7:0]}
    typedef logic [12:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmlk_multich_pulse_seq_if #(.NUM_CH(NCH), .CNT_W(CW), .STEP_W(SW), .CYC_W(YW), .DECI_W(DW)) bus ();

    cmlk_multich_pulse_seq #(.NUM_CH(NCH), .CNT_W(CW), .STEP_W(SW), .CYC_W(YW), .DECI_W(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_active = 1'b0;

    function automatic vec_t mk(bit l, bit g1, bit g0, bit fs, bit bg, int st);
        logic [7:0] s;
        s = 8'(st);
        return {l, g1, g0, fs, bg, s};
    endfunction

    // One period of expected outputs for given effective delays of this period
    task automatic push_period(int p, int lw, int d0, int w0, int d1, int w1, bit first, bit bg, int st);
        for (int c = 0; c < p; c++)
            exp_q.push_back(mk(!bg && c < lw, c >= d1 && c < d1 + w1, c >= d0 && c < d0 + w0,
                               first && c == 0, bg, st));
    endtask

    always @(negedge clk) begin : monitor
        vec_t act;
        vec_t e;
        act = {bus.laser_pulse, bus.gate_pulse, bus.frame_start, bus.frame_bg, bus.step_idx};
        if (!mon_active && bus.frame_start && exp_q.size() > 0) mon_active = 1'b1;
        if (mon_active) begin
            if (exp_q.size() == 0) begin
                mon_active = 1'b0;
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL pulse_vec t=%0t got l=%b g=%b fs=%b bg=%b st=%0d want l=%b g=%b fs=%b bg=%b st=%0d",
                             $time, act[12], act[11:10], act[9], act[8], act[7:0],
                             e[12], e[11:10], e[9], e[8], e[7:0]);
                end
                if (exp_q.size() == 0) mon_active = 1'b0;
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    function automatic logic [14:0] all_out();
        return {bus.laser_pulse, bus.gate_pulse, bus.frame_start, bus.frame_bg,
                bus.step_idx, bus.busy, bus.load_pending};
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_params(int p, int lw, int d0, int w0, int d1, int w1, int s0, int s1,
                              int cyc, int stp, int deci);
        bus.laser_period = CW'(p);
        bus.laser_width  = CW'(lw);
        bus.ch_delay     = {CW'(d1), CW'(d0)};
        bus.ch_width     = {CW'(w1), CW'(w0)};
        bus.ch_step      = {SW'(s1), SW'(s0)};
        bus.cycles_m     = YW'(cyc);
        bus.steps_n      = YW'(stp);
        bus.bg_deci_n    = DW'(deci);
    endtask

    task automatic pulse_load();
        bus.load_param = 1'b1;
        tick(1);
        bus.load_param = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_fs(int budget);
        int n;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk("frame_start_seen", 64'(bus.frame_start), 64'd1);
    endtask

    task automatic stop_seq();
        bus.enable = 1'b0;
        tick(3);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int starts[6];
        int n;
        starts = '{1, 1, 4, 4, 7, 7};
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.load_param = 1'b0;
        set_params(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(3);
        chk("reset_outputs", 64'(all_out()), 64'd0);
        rst = 1'b0;
        tick(2);
        chk("idle_outputs", 64'(all_out()), 64'd0);

        // Basic timing; a later unloaded width change must not matter
        set_params(10, 3, 2, 2, 4, 2, 0, 0, 1, 1, 0);
        pulse_load();
        for (int f = 0; f < 3; f++) push_period(10, 3, 2, 2, 4, 2, 1'b1, 1'b0, 0);
        bus.enable = 1'b1;
        tick(5);
        chk("busy_run", 64'(bus.busy), 64'd1);
        bus.laser_width = CW'(7);
        wait_drain(100);
        stop_seq();

        // Delay sweep over 3 steps of 2 periods, then back to step 0
        set_params(20, 3, 1, 2, 0, 0, 3, 0, 2, 3, 0);
        pulse_load();
        for (int k = 0; k < 6; k++) push_period(20, 3, starts[k], 2, 0, 0, k == 0, 1'b0, k / 2);
        push_period(20, 3, 1, 2, 0, 0, 1'b1, 1'b0, 0);
        bus.enable = 1'b1;
        wait_drain(300);
        stop_seq();

        // Background decimation: frame 2 of every 3
        set_params(10, 3, 2, 2, 4, 2, 0, 0, 1, 1, 3);
        pulse_load();
        for (int f = 0; f < 4; f++) push_period(10, 3, 2, 2, 4, 2, 1'b1, f == 2, 0);
        bus.enable = 1'b1;
        wait_drain(100);
        stop_seq();

        // Deferred load: width 3 -> 5 from the next frame
        set_params(10, 3, 2, 2, 4, 2, 0, 0, 2, 1, 0);
        pulse_load();
        push_period(10, 3, 2, 2, 4, 2, 1'b1, 1'b0, 0);
        push_period(10, 3, 2, 2, 4, 2, 1'b0, 1'b0, 0);
        for (int f = 0; f < 2; f++) begin
            push_period(10, 5, 2, 2, 4, 2, 1'b1, 1'b0, 0);
            push_period(10, 5, 2, 2, 4, 2, 1'b0, 1'b0, 0);
        end
        bus.enable = 1'b1;
        wait_fs(50);
        tick(4);
        bus.laser_width = CW'(5);
        pulse_load();
        chk("load_pending_set", 64'(bus.load_pending), 64'd1);
        tick(10);
        chk("load_pending_held", 64'(bus.load_pending), 64'd1);
        wait_drain(100);
        chk("load_pending_clear", 64'(bus.load_pending), 64'd0);
        stop_seq();

        // Degenerate period/cycles/steps, gate clipped at the period end
        set_params(0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0);
        pulse_load();
        for (int f = 0; f < 3; f++) push_period(2, 1, 0, 1, 1, 5, 1'b1, 1'b0, 0);
        bus.enable = 1'b1;
        wait_drain(50);
        stop_seq();

        // Laser width >= period, gate clip 8-9, swept gate reaching the period end
        set_params(10, 15, 8, 5, 4, 3, 0, 3, 1, 3, 0);
        pulse_load();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 3; k++) push_period(10, 15, 8, 5, 4 + 3 * k, 3, k == 0, 1'b0, k);
        bus.enable = 1'b1;
        wait_drain(150);
        stop_seq();

        // Async reset during an active gate
        set_params(10, 3, 2, 2, 4, 2, 0, 0, 1, 1, 0);
        pulse_load();
        bus.enable = 1'b1;
        n = 0;
        while (bus.gate_pulse[0] !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        chk("gate_seen_before_rst", 64'(bus.gate_pulse[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 64'(all_out()), 64'd0);
        bus.enable = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // Enable drop mid-period, then restart from step 0
        set_params(10, 3, 2, 2, 4, 2, 0, 0, 1, 1, 0);
        pulse_load();
        bus.enable = 1'b1;
        wait_fs(50);
        tick(4);
        bus.enable = 1'b0;
        tick(2);
        chk("disable_outputs", 64'(all_out()), 64'd0);
        push_period(10, 3, 2, 2, 4, 2, 1'b1, 1'b0, 0);
        push_period(10, 3, 2, 2, 4, 2, 1'b1, 1'b0, 0);
        bus.enable = 1'b1;
        wait_drain(60);
        stop_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
